// File: rtl/frame_fifo_read_2d.sv
// frame_fifo_read_2d: strided multi-buffer frame reader issuing FIFO-throttled DDR3 burst reads
module frame_fifo_read_2d #(
    parameter int MEM_DATA_BITS = 32,
    parameter int ADDR_BITS     = 23,
    parameter int BURST_BITS    = 10,
    parameter int FIFO_DEPTH    = 256,
    parameter int FIFO_MARGIN   = 2,
    parameter int BURST_SIZE    = 128,
    parameter int NUM_BUF       = 3,
    parameter int IDX_BITS      = 2,
    parameter int WAIT_CYCLES   = 200
) (
    input  logic                         mem_clk,
    input  logic                         rst,
    output logic                         rd_burst_req,
    output logic [BURST_BITS-1:0]        rd_burst_len,
    output logic [ADDR_BITS-1:0]         rd_burst_addr,
    input  logic                         rd_burst_data_valid,
    input  logic                         rd_burst_finish,
    input  logic                         read_req,
    output logic                         read_req_ack,
    output logic                         read_finish,
    input  logic [NUM_BUF*ADDR_BITS-1:0] read_base_addr,
    input  logic [IDX_BITS-1:0]          read_addr_index,
    input  logic [ADDR_BITS-1:0]         read_line_words,
    input  logic [15:0]                  read_line_num,
    input  logic [ADDR_BITS-1:0]         read_line_stride,
    output logic                         fifo_aclr,
    input  logic [15:0]                  wrusedw
);
    // FIFO fill ceiling; the data width only documents the memory bus
    localparam int FILL_MAX = (MEM_DATA_BITS > 0) ? FIFO_DEPTH - FIFO_MARGIN : 0;
    localparam int WB = $clog2(WAIT_CYCLES + 1);

    typedef enum logic [2:0] {S_IDLE, S_ACK, S_WAIT, S_CHECK, S_BURST, S_BEND, S_END} state_t;

    state_t                state_q;
    logic [2:0]            req_q;
    logic [IDX_BITS-1:0]   idx_m_q, idx_s_q;
    logic [ADDR_BITS-1:0]  words_m_q, words_s_q, stride_m_q, stride_s_q;
    logic [15:0]           num_m_q, num_s_q;
    logic [ADDR_BITS-1:0]  line_words_q, stride_q, line_addr_q, word_cnt_q;
    logic [15:0]           line_num_q, line_cnt_q;
    logic [WB-1:0]         wait_cnt_q;
    logic                  req_s;
    logic [ADDR_BITS-1:0]  base_w, rem_w;
    logic [BURST_BITS-1:0] len_w;
    logic                  fits_w;

    assign req_s = req_q[2];

    // buffer select, line-end clipped burst length and FIFO room check
    always_comb begin
        base_w = (32'(idx_s_q) < NUM_BUF) ? read_base_addr[idx_s_q*ADDR_BITS +: ADDR_BITS]
                                          : read_base_addr[ADDR_BITS-1:0];
        rem_w  = line_words_q - word_cnt_q;
        len_w  = (rem_w < ADDR_BITS'(BURST_SIZE)) ? rem_w[BURST_BITS-1:0] : BURST_BITS'(BURST_SIZE);
        fits_w = ({1'b0, wrusedw} + 17'(len_w)) <= 17'(FILL_MAX);
    end

    // cross the request and frame geometry from the video clock domain
    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            req_q      <= '0;
            idx_m_q    <= '0;
            idx_s_q    <= '0;
            words_m_q  <= '0;
            words_s_q  <= '0;
            num_m_q    <= '0;
            num_s_q    <= '0;
            stride_m_q <= '0;
            stride_s_q <= '0;
        end else begin
            req_q      <= {req_q[1:0], read_req};
            idx_m_q    <= read_addr_index;
            idx_s_q    <= idx_m_q;
            words_m_q  <= read_line_words;
            words_s_q  <= words_m_q;
            num_m_q    <= read_line_num;
            num_s_q    <= num_m_q;
            stride_m_q <= read_line_stride;
            stride_s_q <= stride_m_q;
        end
    end

    // frame sequencer: handshake, settle, then line-by-line bursts gated by FIFO room
    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            rd_burst_req  <= 1'b0;
            rd_burst_len  <= '0;
            rd_burst_addr <= '0;
            read_req_ack  <= 1'b0;
            read_finish   <= 1'b0;
            fifo_aclr     <= 1'b0;
            line_words_q  <= '0;
            line_num_q    <= '0;
            stride_q      <= '0;
            line_addr_q   <= '0;
            word_cnt_q    <= '0;
            line_cnt_q    <= '0;
            wait_cnt_q    <= '0;
        end else begin
            read_finish <= 1'b0;
            case (state_q)
                S_IDLE: if (req_s) state_q <= S_ACK;
                S_ACK: begin
                    if (req_s) begin
                        read_req_ack  <= 1'b1;
                        fifo_aclr     <= 1'b1;
                        line_words_q  <= words_s_q;
                        line_num_q    <= num_s_q;
                        stride_q      <= stride_s_q;
                        line_addr_q   <= base_w;
                        rd_burst_addr <= base_w;
                        word_cnt_q    <= '0;
                        line_cnt_q    <= '0;
                    end else begin
                        read_req_ack <= 1'b0;
                        fifo_aclr    <= 1'b0;
                        wait_cnt_q   <= '0;
                        state_q      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt_q == WB'(WAIT_CYCLES))
                        state_q <= (line_words_q == '0 || line_num_q == '0) ? S_END : S_CHECK;
                    else
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                end
                S_CHECK: begin
                    if (req_s) state_q <= S_ACK;
                    else if (fits_w) begin
                        rd_burst_len <= len_w;
                        rd_burst_req <= 1'b1;
                        state_q      <= S_BURST;
                    end
                end
                S_BURST: begin
                    if (rd_burst_data_valid) rd_burst_req <= 1'b0;
                    if (rd_burst_finish) begin
                        rd_burst_req  <= 1'b0;
                        word_cnt_q    <= word_cnt_q + ADDR_BITS'(rd_burst_len);
                        rd_burst_addr <= rd_burst_addr + ADDR_BITS'(rd_burst_len);
                        state_q       <= S_BEND;
                    end
                end
                S_BEND: begin
                    if (req_s) state_q <= S_ACK;
                    else if (word_cnt_q < line_words_q) state_q <= S_CHECK;
                    else begin
                        line_cnt_q <= line_cnt_q + 16'd1;
                        if (line_cnt_q + 16'd1 == line_num_q) state_q <= S_END;
                        else begin
                            line_addr_q   <= line_addr_q + stride_q;
                            rd_burst_addr <= line_addr_q + stride_q;
                            word_cnt_q    <= '0;
                            state_q       <= S_CHECK;
                        end
                    end
                end
                S_END: begin
                    read_finish <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule
